// File: rtl/bin_enc8to3_seq.sv
// Sequential 8-to-3 encoder: captures a code word and streams the index of each set bit over valid/ready.
// Optional one-hot violation flag enabled by defining BIN_ENC_ONEHOT_CHECK_EN.
module bin_enc8to3_seq #(
  parameter int N         = 8,
  parameter int CW        = 3,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  bcode,
  input  logic          load,
  output logic [CW-1:0] code,
  output logic          code_valid,
  input  logic          code_ready,
  output logic          code_last,
  output logic          busy,
  output logic          done,
  output logic          zero_word,
  output logic          multi_err
);

  typedef enum logic {S_IDLE, S_SEND} state_t;

  state_t         r_state;
  logic [N-1:0]   r_pending;
  logic [N-1:0]   w_rem;
  logic [CW-1:0]  w_load_sel;
  logic [CW-1:0]  w_rem_sel;
  logic           w_load_one;
  logic           w_rem_one;

  function automatic logic [CW-1:0] f_sel(input logic [N-1:0] w);
    logic [CW-1:0] v_idx;
    logic          v_found;
    v_idx   = '0;
    v_found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (MSB_FIRST) begin
        if (w[i]) v_idx = CW'(i);
      end else if (w[i] && !v_found) begin
        v_idx   = CW'(i);
        v_found = 1'b1;
      end
    end
    return v_idx;
  endfunction

  function automatic logic f_onehot(input logic [N-1:0] w);
    return (w != '0) && ((w & (w - N'(1))) == '0);
  endfunction

  // r_pending still contains the bit currently being presented on code.
  always_comb begin
    w_rem      = r_pending & ~(N'(1) << code);
    w_load_sel = f_sel(bcode);
    w_load_one = f_onehot(bcode);
    w_rem_sel  = f_sel(w_rem);
    w_rem_one  = f_onehot(w_rem);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_pending  <= '0;
      code       <= '0;
      code_valid <= 1'b0;
      code_last  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      zero_word  <= 1'b0;
    end else begin
      done      <= 1'b0;
      zero_word <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (load) begin
            if (bcode == '0) begin
              zero_word <= 1'b1;
            end else begin
              r_pending  <= bcode;
              code       <= w_load_sel;
              code_last  <= w_load_one;
              code_valid <= 1'b1;
              busy       <= 1'b1;
              r_state    <= S_SEND;
            end
          end
        end
        S_SEND: begin
          if (code_ready) begin
            if (code_last) begin
              r_pending  <= '0;
              code       <= '0;
              code_valid <= 1'b0;
              code_last  <= 1'b0;
              busy       <= 1'b0;
              done       <= 1'b1;
              r_state    <= S_IDLE;
            end else begin
              r_pending <= w_rem;
              code      <= w_rem_sel;
              code_last <= w_rem_one;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef BIN_ENC_ONEHOT_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      multi_err <= 1'b0;
    end else if (r_state == S_IDLE && load) begin
      multi_err <= (bcode & (bcode - N'(1))) != '0;
    end
  end
`else
  assign multi_err = 1'b0;
`endif

endmodule

// File: tb/tb_bin_enc8to3_seq.sv
// Randomized and directed bench for bin_enc8to3_seq against a queue-based transfer model.
module tb_bin_enc8to3_seq;
  localparam bit MSBF = 1'b0;
`ifdef BIN_ENC_ONEHOT_CHECK_EN
  localparam bit MERR_EN = 1'b1;
`else
  localparam bit MERR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] bcode = '0;
  logic       load = 1'b0;
  logic       code_ready = 1'b0;
  logic [2:0] code;
  logic       code_valid, code_last, busy, done, zero_word, multi_err;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  int q[$];
  bit m_done, m_zero, m_merr;

  bin_enc8to3_seq #(.N(8), .CW(3), .MSB_FIRST(MSBF)) dut (
    .clk(clk), .rst_n(rst_n), .bcode(bcode), .load(load), .code(code),
    .code_valid(code_valid), .code_ready(code_ready), .code_last(code_last),
    .busy(busy), .done(done), .zero_word(zero_word), .multi_err(multi_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a batch is the ordered list of set indices; one pops per accepted transfer.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_done = 1'b0;
      m_zero = 1'b0;
      m_merr = 1'b0;
    end else begin
      m_done = 1'b0;
      m_zero = 1'b0;
      if (q.size() != 0) begin
        if (code_ready) begin
          void'(q.pop_front());
          if (q.size() == 0) m_done = 1'b1;
        end
      end else if (load) begin
        if (bcode == 8'h00) m_zero = 1'b1;
        for (int k = 0; k < 8; k++) begin
          int b;
          b = MSBF ? 7 - k : k;
          if (bcode[b]) q.push_back(b);
        end
        if (MERR_EN) m_merr = ($countones(bcode) >= 2);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      logic [8:0] e, a;
      e = {q.size() != 0, q.size() == 1, q.size() != 0, m_done, m_zero, m_merr,
           (q.size() != 0) ? 3'(q[0]) : 3'd0};
      a = {code_valid, code_last, busy, done, zero_word, multi_err, code};
      chk("model {valid,last,busy,done,zero,merr,code}", int'(a), int'(e));
    end
  end

  task automatic wait_idle();
    int n = 0;
    load = 1'b0;
    code_ready = 1'b1;
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("wait_idle timeout", int'(busy), 0);
  endtask

  task automatic do_load(input logic [7:0] w, input logic rdy);
    bcode = w;
    load = 1'b1;
    code_ready = rdy;
    @(negedge clk);
    load = 1'b0;
  endtask

  initial begin
    int exp_a6[4];
    int exp_81[2];
    exp_a6 = MSBF ? '{7, 5, 2, 1} : '{1, 2, 5, 7};
    exp_81 = MSBF ? '{7, 0} : '{0, 7};

    #2;
    chk_on = 1'b1;
    chk("reset outputs", int'({code_valid, code_last, busy, done, zero_word, multi_err, code}), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      do_load(8'(1 << i), 1'b1);
      chk("onehot code", int'(code), i);
      chk("onehot last", int'(code_last), 1);
      @(negedge clk);
      chk("onehot done", int'({done, busy, code_valid}), 3'b100);
    end

    do_load(8'b1010_0110, 1'b1);
    for (int k = 0; k < 4; k++) begin
      chk("multihot code", int'(code), exp_a6[k]);
      chk("multihot last", int'(code_last), (k == 3) ? 1 : 0);
      @(negedge clk);
    end
    chk("multihot done", int'(done), 1);

    do_load(8'h81, 1'b0);
    repeat (3) begin
      chk("stall code", int'({code_valid, code}), {1'b1, 3'(exp_81[0])});
      @(negedge clk);
    end
    code_ready = 1'b1;
    @(negedge clk);
    chk("stall second", int'({code_valid, code_last, code}), {2'b11, 3'(exp_81[1])});
    @(negedge clk);
    chk("stall done", int'(done), 1);

    do_load(8'h00, 1'b1);
    chk("zero word", int'({zero_word, code_valid}), 2'b10);
    do_load(8'h03, 1'b0);
    do_load(8'hFF, 1'b1);
    chk("ignored load 2nd code", int'(code), MSBF ? 0 : 1);
    @(negedge clk);
    chk("ignored load done", int'({done, busy}), 2'b10);

    for (int c = 0; c < 400; c++) begin
      int r;
      r = $urandom_range(0, 3);
      bcode = (r == 0) ? 8'h00 : (r == 1) ? 8'(1 << $urandom_range(0, 7)) : 8'($urandom);
      load = ($urandom_range(0, 2) == 0);
      code_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
    end
    wait_idle();

    do_load(8'hFF, 1'b1);
    repeat (3) @(negedge clk);
    #3 rst_n = 1'b0;
    #1 chk("async reset", int'({code_valid, code_last, busy, done, zero_word, multi_err, code}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("no done after reset", int'(done), 0);
    do_load(8'h10, 1'b1);
    chk("post-reset code", int'({code_valid, code}), {1'b1, 3'd4});
    @(negedge clk);

`ifdef BIN_ENC_ONEHOT_CHECK_EN
    do_load(8'h0C, 1'b1);
    chk("merr set", int'({multi_err, code}), {1'b1, MSBF ? 3'd3 : 3'd2});
    @(negedge clk);
    chk("merr second code", int'({multi_err, code}), {1'b1, MSBF ? 3'd2 : 3'd3});
    @(negedge clk);
    do_load(8'h02, 1'b1);
    chk("merr cleared", int'(multi_err), 0);
    @(negedge clk);
`endif

    chk_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end
endmodule
